intraloop_mb_scheduler: RTL and testbench
=========================================

// Module: intraloop_mb_scheduler
// PURPOSE
//  Upstream sequencer for the intra loop. It walks one frame macroblock by macroblock,
//  issuing block numbers and an enable pulse for every 4x4 luma block, and waits for
//  the reconstructor's fb_* done strobes before issuing the next block.
//  Drives mbnumber_luma4x4/chromab8x8/chromar8x8 and enable into the intra loop.
//  Format is 4:2:0: each MB has 16 luma 4x4 blocks, 1 Cb 8x8 block and 1 Cr 8x8 block.
// PARAMETERS
//  FRAME_W         64    frame width in luma pixels; must be a multiple of 16
//  FRAME_H         48    frame height in luma pixels; must be a multiple of 16
//  TIMEOUT_CYCLES  1024  watchdog limit in cycles (used only with the macro below)
// PORTS
//  clk                  in   1   clock, rising edge
//  reset                in   1   asynchronous, active-low reset
//  start                in   1   begin frame; sampled only in IDLE
//  fb_luma4x4           in   1   1-cycle strobe: current luma block reconstructed
//  fb_chromab8x8        in   1   1-cycle strobe: current MB Cb block reconstructed
//  fb_chromar8x8        in   1   1-cycle strobe: current MB Cr block reconstructed
//  enable               out  1   1-cycle issue pulse to the intra loop
//  mbnumber_luma4x4     out  32  raster index of the 4x4 luma block in the frame
//  mbnumber_chromab8x8  out  32  MB raster index (Cb 8x8 block number)
//  mbnumber_chromar8x8  out  32  MB raster index (Cr 8x8 block number)
//  busy                 out  1   frame in progress
//  frame_done           out  1   1-cycle pulse at end of frame
//  sched_error          out  1   sticky watchdog error; cleared by reset or accepted start
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; all counters and sticky flags 0. Asynchronous entry;
//   an in-flight frame is abandoned and no frame_done is produced.
//  Constants: MBW=FRAME_W/16, MBH=FRAME_H/16, BW=FRAME_W/4. All registers are 32-bit unsigned.
//  FSM states: IDLE, ISSUE, WAIT, MBEND, DONE.
//  IDLE:  start=1 -> mb_x=mb_y=blk=0, sched_error=0, busy=1, go to ISSUE.
//   The first enable is asserted 1 cycle after start is sampled.
//  ISSUE: enable=1 for exactly this cycle. mbnumber_* are registered and valid in this
//   cycle, then held until the next ISSUE.
//   luma = (mb_y*4+by)*BW + mb_x*4 + bx, where bx={blk[2],blk[0]} and by={blk[3],blk[1]}
//   (H.264 8x8 Z-order). chromab = chromar = mb_y*MBW + mb_x.
//   If blk==0, clear the Cb/Cr sticky flags. Go to WAIT.
//  Cb/Cr sticky flags: set by fb_chromab8x8/fb_chromar8x8 in any cycle except
//   ISSUE-with-blk==0 (clear has priority). Simultaneous fb strobes are all captured.
//  WAIT: fb_luma4x4=1 -> if blk<15: blk++ and go to ISSUE (next enable the following cycle);
//   else go to MBEND. fb_luma4x4 outside WAIT is ignored.
//  MBEND: both sticky flags set (may already be set on entry; then 1 cycle) ->
//   if mb_x==MBW-1 and mb_y==MBH-1: go to DONE;
//   else mb_x++ (wrap to 0 with mb_y++), blk=0, go to ISSUE.
//  DONE: frame_done=1 for one cycle, busy=0 from the next cycle, go to IDLE.
//   start during DONE is ignored.
//  busy=1 from the cycle after start is accepted through the DONE cycle inclusive.
//   start while busy is ignored.
// CONFIGURATION
//  INTRALOOP_SCHED_TIMEOUT_EN defined: a counter resets on entering WAIT or MBEND and
//   increments each cycle spent there. On reaching TIMEOUT_CYCLES: sched_error=1 (sticky),
//   go to DONE (frame_done pulses, the frame is aborted).
//  Not defined: no counter; WAIT/MBEND wait indefinitely; sched_error is tied to 0.
// TESTING  (FRAME_W=32, FRAME_H=16: MBW=2, MBH=1, BW=8)
//  Reset values: assert reset low mid-run -> all outputs 0 immediately; after release,
//   enable stays 0 until start.
//  Nominal frame: fb_luma4x4 returned 3 cycles after each enable; Cb/Cr returned with the
//   16th luma strobe -> MB0 luma sequence 0,1,8,9,2,3,10,11,16,17,24,25,18,19,26,27;
//   MB1 is the same +4; chroma numbers 0 then 1; 32 enables total; one frame_done.
//  Chroma early/late: Cb/Cr strobed during MB0 block 3 -> MB1 issues 1 cycle after MBEND
//   entry; Cb strobed 20 cycles after the 16th luma done -> no enable before that.
//  Start filtering: start held high for the whole frame -> exactly one frame runs, and
//   a new frame begins in the cycle after returning to IDLE if start is still high.
//  Reset mid-frame: reset during MB1 blk 5 -> busy=0 and frame_done never pulses;
//   a fresh start restarts at luma 0.
//  Watchdog (macro on, TIMEOUT_CYCLES=16): withhold fb_luma4x4 after the first enable ->
//   sched_error=1 and frame_done pulse 16 cycles after WAIT entry; next start clears sched_error.

Source files
------------

// File: rtl/intraloop_mb_scheduler.sv
// Intra-loop macroblock scheduler: walks a 4:2:0 frame MB by MB and issues each 4x4 luma
// block in 8x8 Z-order, gated by reconstructor done strobes. Watchdog: INTRALOOP_SCHED_TIMEOUT_EN.
module intraloop_mb_scheduler #(
  parameter int unsigned FRAME_W        = 64,
  parameter int unsigned FRAME_H        = 48,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        fb_luma4x4,
  input  logic        fb_chromab8x8,
  input  logic        fb_chromar8x8,
  output logic        enable,
  output logic [31:0] mbnumber_luma4x4,
  output logic [31:0] mbnumber_chromab8x8,
  output logic [31:0] mbnumber_chromar8x8,
  output logic        busy,
  output logic        frame_done,
  output logic        sched_error,
  output logic [2:0]  state_dbg
);

  // Handshake: enable is a one-cycle issue pulse with mbnumber_* valid in that cycle; the
  // next block is issued only after fb_luma4x4 is seen in WAIT (and, at MB end, both chroma
  // strobes have been captured). Inputs are single-cycle strobes, not level handshakes.

  localparam logic [31:0] MBW = 32'(FRAME_W / 16);
  localparam logic [31:0] MBH = 32'(FRAME_H / 16);
  localparam logic [31:0] BW  = 32'(FRAME_W / 4);

  if ((FRAME_W % 16) != 0 || (FRAME_H % 16) != 0 || FRAME_W == 0 || FRAME_H == 0 ||
      TIMEOUT_CYCLES == 0) begin : g_bad_cfg
    $error("intraloop_mb_scheduler: invalid frame size or timeout parameter");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_MBEND = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t      state;
  logic [31:0] mb_x;
  logic [31:0] mb_y;
  logic [31:0] blk;
  logic        cb_seen;
  logic        cr_seen;
  logic [31:0] blk_inc;
  logic [31:0] nx_x;
  logic [31:0] nx_y;
  logic        last_mb;
  logic        clr_flags;
  logic        chroma_ok;
  logic        wd_fire;

  assign state_dbg = state;

  // Block index bits interleave as {by1,bx1,by0,bx0} to give 8x8 Z-order inside the MB.
  function automatic logic [31:0] luma_idx(input logic [31:0] mx, input logic [31:0] my,
                                           input logic [3:0] b);
    logic [31:0] bx;
    logic [31:0] by;
    bx = {30'd0, b[2], b[0]};
    by = {30'd0, b[3], b[1]};
    return (my * 32'd4 + by) * BW + mx * 32'd4 + bx;
  endfunction

  assign blk_inc   = blk + 32'd1;
  assign last_mb   = (mb_x == MBW - 32'd1) && (mb_y == MBH - 32'd1);
  assign nx_x      = (mb_x == MBW - 32'd1) ? 32'd0 : mb_x + 32'd1;
  assign nx_y      = (mb_x == MBW - 32'd1) ? mb_y + 32'd1 : mb_y;
  assign clr_flags = (state == S_ISSUE) && (blk == 32'd0);
  assign chroma_ok = cb_seen && cr_seen;

`ifdef INTRALOOP_SCHED_TIMEOUT_EN
  logic [31:0] wd_cnt;

  assign wd_fire = (wd_cnt == 32'(TIMEOUT_CYCLES - 1)) &&
                   (((state == S_WAIT) && !fb_luma4x4) || ((state == S_MBEND) && !chroma_ok));

  // Counter restarts on every WAIT/MBEND entry (WAIT is only entered from ISSUE).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_cnt      <= 32'd0;
      sched_error <= 1'b0;
    end else begin
      if ((state == S_MBEND) || ((state == S_WAIT) && !fb_luma4x4))
        wd_cnt <= wd_cnt + 32'd1;
      else
        wd_cnt <= 32'd0;
      if ((state == S_IDLE) && start)
        sched_error <= 1'b0;
      else if (wd_fire)
        sched_error <= 1'b1;
    end
  end
`else
  assign wd_fire     = 1'b0;
  assign sched_error = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state               <= S_IDLE;
      mb_x                <= 32'd0;
      mb_y                <= 32'd0;
      blk                 <= 32'd0;
      cb_seen             <= 1'b0;
      cr_seen             <= 1'b0;
      enable              <= 1'b0;
      mbnumber_luma4x4    <= 32'd0;
      mbnumber_chromab8x8 <= 32'd0;
      mbnumber_chromar8x8 <= 32'd0;
      busy                <= 1'b0;
      frame_done          <= 1'b0;
    end else begin
      enable     <= 1'b0;
      frame_done <= 1'b0;
      if (clr_flags) begin
        cb_seen <= 1'b0;
        cr_seen <= 1'b0;
      end else begin
        if (fb_chromab8x8) cb_seen <= 1'b1;
        if (fb_chromar8x8) cr_seen <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (start) begin
            mb_x                <= 32'd0;
            mb_y                <= 32'd0;
            blk                 <= 32'd0;
            busy                <= 1'b1;
            enable              <= 1'b1;
            mbnumber_luma4x4    <= 32'd0;
            mbnumber_chromab8x8 <= 32'd0;
            mbnumber_chromar8x8 <= 32'd0;
            state               <= S_ISSUE;
          end
        end
        S_ISSUE: state <= S_WAIT;
        S_WAIT: begin
          if (fb_luma4x4) begin
            if (blk < 32'd15) begin
              blk              <= blk_inc;
              enable           <= 1'b1;
              mbnumber_luma4x4 <= luma_idx(mb_x, mb_y, blk_inc[3:0]);
              state            <= S_ISSUE;
            end else begin
              state <= S_MBEND;
            end
          end else if (wd_fire) begin
            frame_done <= 1'b1;
            state      <= S_DONE;
          end
        end
        S_MBEND: begin
          if (chroma_ok) begin
            if (last_mb) begin
              frame_done <= 1'b1;
              state      <= S_DONE;
            end else begin
              mb_x                <= nx_x;
              mb_y                <= nx_y;
              blk                 <= 32'd0;
              enable              <= 1'b1;
              mbnumber_luma4x4    <= luma_idx(nx_x, nx_y, 4'd0);
              mbnumber_chromab8x8 <= nx_y * MBW + nx_x;
              mbnumber_chromar8x8 <= nx_y * MBW + nx_x;
              state               <= S_ISSUE;
            end
          end else if (wd_fire) begin
            frame_done <= 1'b1;
            state      <= S_DONE;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_intraloop_mb_scheduler.sv
// Directed bench for intraloop_mb_scheduler on a 32x16 frame (2x1 MBs); a scoreboard queue
// holds expected block numbers and a built-in responder returns the fb_* strobes.
module tb_intraloop_mb_scheduler;

  localparam int unsigned FW = 32;
  localparam int unsigned FH = 16;
  localparam int NMB = (FW / 16) * (FH / 16);
  localparam int NEN = NMB * 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        fb_l = 1'b0;
  logic        fb_b = 1'b0;
  logic        fb_r = 1'b0;
  logic        enable;
  logic [31:0] luma;
  logic [31:0] cb;
  logic [31:0] cr;
  logic        busy;
  logic        frame_done;
  logic        sched_error;
  logic [2:0]  state_dbg;

  intraloop_mb_scheduler #(.FRAME_W(FW), .FRAME_H(FH), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .start(start),
    .fb_luma4x4(fb_l), .fb_chromab8x8(fb_b), .fb_chromar8x8(fb_r),
    .enable(enable), .mbnumber_luma4x4(luma), .mbnumber_chromab8x8(cb),
    .mbnumber_chromar8x8(cr), .busy(busy), .frame_done(frame_done),
    .sched_error(sched_error), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_c[$];
  int zx[16] = '{0, 1, 0, 1, 2, 3, 2, 3, 0, 1, 0, 1, 2, 3, 2, 3};
  int zy[16] = '{0, 0, 1, 1, 0, 0, 1, 1, 2, 2, 3, 3, 2, 2, 3, 3};

  int cyc = 0;
  int en_seq = 0;
  int done_cnt = 0;
  int done_cyc = -1;
  logic busy_at_done = 1'b0;
  int fire_timer = 0;
  int fire_blk = 0;
  int fire_idx = 0;
  int cb_timer = 0;
  int chroma_mode = 0;
  bit luma_on = 1'b1;
  int fb16_cyc = -1;
  int mb1_en_cyc = -1;
  int cb_cyc = -1;
  int first_en_cyc = -1;
  int frame_start_cyc = -1;
  int start_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Expected issue order built from pixel coordinates and a Z-order lookup table.
  task automatic push_frame();
    for (int mb = 0; mb < NMB; mb++) begin
      for (int b = 0; b < 16; b++) begin
        exp_q.push_back(32'(((mb / 2) * 4 + zy[b]) * (FW / 4) + (mb % 2) * 4 + zx[b]));
        exp_c.push_back(32'(mb));
      end
    end
  endtask

  // One clock: sample outputs 1 time unit after the edge, then drive this cycle's strobes.
  task automatic tick();
    logic [31:0] e;
    logic [31:0] c;
    int idx;
    @(posedge clk);
    #1;
    cyc++;
    fb_l = 1'b0;
    fb_b = 1'b0;
    fb_r = 1'b0;
    if (cb_timer > 0) begin
      cb_timer--;
      if (cb_timer == 0) begin
        fb_b = 1'b1;
        if (cb_cyc < 0) cb_cyc = cyc;
      end
    end
    if (fire_timer > 0) begin
      fire_timer--;
      if (fire_timer == 0) begin
        fb_l = luma_on;
        if (fire_idx == 15) fb16_cyc = cyc;
        case (chroma_mode)
          0: if (fire_blk == 15) begin fb_b = 1'b1; fb_r = 1'b1; end
          1: if (fire_blk == 3) begin fb_b = 1'b1; fb_r = 1'b1; end
          default: if (fire_blk == 15) begin fb_r = 1'b1; cb_timer = 20; end
        endcase
      end
    end
    if (enable) begin
      chk("enable_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        c = exp_c.pop_front();
        chk("luma_number", luma, e);
        chk("cb_number", cb, c);
        chk("cr_number", cr, c);
      end
      idx = en_seq % NEN;
      if (en_seq == 0) first_en_cyc = cyc;
      if (idx == 0) frame_start_cyc = cyc;
      if (idx == 16) mb1_en_cyc = cyc;
      fire_blk = en_seq % 16;
      fire_idx = idx;
      fire_timer = 3;
      en_seq++;
    end
    if (frame_done) begin
      done_cnt++;
      done_cyc = cyc;
      busy_at_done = busy;
    end
  endtask

  task automatic begin_frame(input bit single);
    if (single) begin
      exp_q.push_back(32'd0);
      exp_c.push_back(32'd0);
    end else begin
      push_frame();
    end
    en_seq = 0;
    first_en_cyc = -1;
    fb16_cyc = -1;
    mb1_en_cyc = -1;
    cb_cyc = -1;
    start = 1'b1;
    start_cyc = cyc;
    tick();
    start = 1'b0;
    chk("first_enable_latency", 32'(first_en_cyc), 32'(start_cyc + 1));
  endtask

  task automatic run_until_done(input int budget);
    int d0;
    int n;
    d0 = done_cnt;
    n = 0;
    while (done_cnt == d0 && n < budget) begin
      tick();
      n++;
    end
    chk("frame_done_within_budget", 32'(done_cnt != d0), 32'd1);
  endtask

  initial begin
    int d0;
    int e0;
    int n;
    int dref;

    // Reset state
    repeat (3) tick();
    chk("rst_enable", 32'(enable), 32'd0);
    chk("rst_luma", luma, 32'd0);
    chk("rst_cb", cb, 32'd0);
    chk("rst_cr", cr, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_sched_error", 32'(sched_error), 32'd0);
    chk("rst_state_idle", 32'(state_dbg), 32'd0);
    reset = 1'b1;
    repeat (6) tick();
    chk("no_enable_before_start", 32'(en_seq), 32'd0);

    // Nominal frame, chroma with 16th luma strobe
    chroma_mode = 0;
    begin_frame(1'b0);
    chk("busy_in_frame", 32'(busy), 32'd1);
    run_until_done(400);
    chk("nominal_enable_count", 32'(en_seq), 32'(NEN));
    chk("nominal_queue_drained", 32'(exp_q.size()), 32'd0);
    chk("nominal_done_count", 32'(done_cnt), 32'd1);
    chk("busy_during_done", 32'(busy_at_done), 32'd1);
    chk("nominal_mb1_issue", 32'(mb1_en_cyc), 32'(fb16_cyc + 2));
    tick();
    chk("busy_after_done", 32'(busy), 32'd0);
    chk("frame_done_one_cycle", 32'(frame_done), 32'd0);
    repeat (5) tick();
    chk("single_frame_done", 32'(done_cnt), 32'd1);

    // Chroma early: strobed during block 3 of each MB
    chroma_mode = 1;
    begin_frame(1'b0);
    run_until_done(400);
    chk("early_mb1_issue", 32'(mb1_en_cyc), 32'(fb16_cyc + 2));
    chk("early_enable_count", 32'(en_seq), 32'(NEN));

    // Chroma late: Cb arrives 20 cycles after the 16th luma done
    chroma_mode = 2;
    repeat (3) tick();
    begin_frame(1'b0);
    run_until_done(600);
    chk("late_cb_delay", 32'(cb_cyc), 32'(fb16_cyc + 20));
    chk("late_mb1_issue", 32'(mb1_en_cyc), 32'(cb_cyc + 2));
    chk("late_enable_count", 32'(en_seq), 32'(NEN));

    // Start held high: one frame, then a new one right after returning to IDLE
    chroma_mode = 0;
    repeat (3) tick();
    push_frame();
    push_frame();
    en_seq = 0;
    start = 1'b1;
    run_until_done(400);
    chk("held_start_one_frame", 32'(en_seq), 32'(NEN));
    dref = done_cyc;
    n = 0;
    while (en_seq == NEN && n < 10) begin
      tick();
      n++;
    end
    chk("held_start_restart", 32'(frame_start_cyc), 32'(dref + 2));
    start = 1'b0;
    run_until_done(400);
    chk("held_start_total", 32'(en_seq), 32'(2 * NEN));
    chk("held_start_drained", 32'(exp_q.size()), 32'd0);

    // Reset mid-frame during MB1 block 5
    repeat (3) tick();
    begin_frame(1'b0);
    n = 0;
    while (en_seq < 22 && n < 300) begin
      tick();
      n++;
    end
    chk("reached_mb1_blk5", 32'(luma), 32'd7);
    #2;
    reset = 1'b0;
    #1;
    chk("midrst_enable", 32'(enable), 32'd0);
    chk("midrst_luma", luma, 32'd0);
    chk("midrst_cb", cb, 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    d0 = done_cnt;
    exp_q.delete();
    exp_c.delete();
    fire_timer = 0;
    cb_timer = 0;
    e0 = en_seq;
    repeat (3) tick();
    reset = 1'b1;
    repeat (20) tick();
    chk("midrst_no_done", 32'(done_cnt), 32'(d0));
    chk("midrst_no_enable", 32'(en_seq), 32'(e0));
    begin_frame(1'b0);
    run_until_done(400);
    chk("after_reset_frame", 32'(en_seq), 32'(NEN));

`ifdef INTRALOOP_SCHED_TIMEOUT_EN
    // Watchdog: withhold the first luma strobe
    repeat (3) tick();
    luma_on = 1'b0;
    begin_frame(1'b1);
    run_until_done(100);
    chk("wd_done_time", 32'(done_cyc), 32'(first_en_cyc + 17));
    chk("wd_sched_error", 32'(sched_error), 32'd1);
    tick();
    chk("wd_error_sticky", 32'(sched_error), 32'd1);
    luma_on = 1'b1;
    fire_timer = 0;
    begin_frame(1'b0);
    chk("wd_error_cleared", 32'(sched_error), 32'd0);
    run_until_done(400);
    chk("wd_recover_frame", 32'(en_seq), 32'(NEN));
`else
    chk("sched_error_tied_low", 32'(sched_error), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
